pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5: number of pipeline stages; index 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM.
REQ-002 SHALL have parameter ID_STAGE, default 2: index of the decode stage.
REQ-003 SHALL have parameter EX_STAGE, default 3: index of the execute stage; constraint ID_STAGE < EX_STAGE < NSTAGE-1.
REQ-004 SHALL have parameter ADDR_W, default 32: width of the jump target.
REQ-005 SHALL have parameter TIMEOUT, default 64: number of continuous hold cycles before the timeout flag; range 2..255.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 bus_hold_req_i  in  1  bus wait; stalls the whole pipe.
REQ-009 ex_hold_req_i  in  1  multi-cycle EX operation in progress.
REQ-010 id_hold_req_i  in  1  load-use hazard detected in ID.
REQ-011 jump_req_i  in  1  branch/jump taken in EX.
REQ-012 jump_addr_i  in  ADDR_W  target for jump_req_i.
REQ-013 int_req_i  in  1  interrupt request (level).
REQ-014 int_addr_i  in  ADDR_W  interrupt vector.
REQ-015 hold_en_o  out  NSTAGE  per-stage hold; bit k=1 freezes stage k.
REQ-016 flush_en_o  out  NSTAGE  per-stage flush; bit k=1 loads a bubble into stage k.
REQ-017 jump_en_o  out  1  PC redirect strobe.
REQ-018 jump_addr_o  out  ADDR_W  PC redirect target; 0 when jump_en_o=0.
REQ-019 int_ack_o  out  1  one-cycle pulse; interrupt redirect issued.
REQ-020 hold_timeout_o  out  1  one-cycle pulse; hold has persisted TIMEOUT cycles.

Function
REQ-021 hold_en_o, flush_en_o, jump_en_o and jump_addr_o SHALL be combinational from the inputs and registered state (zero latency).
REQ-022 Priority SHALL be: bus_hold > redirect (int issue, then jump) > ex_hold > id_hold.
REQ-023 bus_hold_req_i=1 SHALL drive hold_en_o = all ones, flush_en_o = 0 and jump_en_o = 0.
REQ-024 A redirect SHALL drive jump_en_o=1, hold_en_o=0, and flush_en_o bits [EX_STAGE:1]=1 with all other bits 0.
REQ-025 ex_hold alone SHALL drive hold_en_o bits [EX_STAGE:0]=1 and flush_en_o bit EX_STAGE+1 = 1 (5'b01111 / 5'b10000 at defaults).
REQ-026 id_hold alone SHALL drive hold_en_o bits [ID_STAGE:0]=1 and flush_en_o bit ID_STAGE+1 = 1.
REQ-027 jump_req_i during bus_hold SHALL set jump_pend and latch jump_addr_i; a later assertion while pending SHALL overwrite the latched address.
REQ-028 In the first cycle without bus_hold with jump_pend or jump_req_i set, exactly one jump SHALL be issued, using jump_addr_i if jump_req_i=1, else the latched address; jump_pend SHALL clear.
REQ-029 The interrupt FSM SHALL have states IDLE, WAIT and ISSUE.
REQ-030 IDLE -> WAIT on int_req_i=1, latching int_addr_i; int_req_i SHALL be ignored outside IDLE.
REQ-031 WAIT -> ISSUE when bus_hold, ex_hold, jump_req_i and jump_pend are all 0.
REQ-032 ISSUE SHALL last one cycle: redirect to the latched vector, int_ack_o=1, then -> IDLE.
REQ-033 A jump or bus_hold arriving in ISSUE SHALL not block the issue; the jump is latched pending and issued the next cycle.
REQ-034 hold_cnt SHALL increment each cycle any hold_en_o bit is 1 and clear to 0 in any cycle with no hold.
REQ-035 hold_timeout_o SHALL pulse in the cycle hold_cnt reaches TIMEOUT-1 while hold persists; hold_cnt then saturates with no further pulse until hold drops.

Reset
REQ-036 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE, and jump_pend, both latched addresses and hold_cnt SHALL be 0, regardless of inputs.
REQ-037 Reset asserted mid-WAIT or mid-hold SHALL discard the pending interrupt, the pending jump and the count.

Structure
REQ-038 Stage indices, FSM state encodings and RstEnable SHALL live in the shared defines file.
REQ-039 The hold counter and timeout pulse SHALL be the sub-module hold_timer (parameter TIMEOUT).

Verification
REQ-040 ex_hold=1 for 3 cycles -> hold_en_o=5'b01111, flush_en_o=5'b10000 each cycle; 0 after.
REQ-041 bus_hold=1 for 4 cycles with jump_req_i=1 and addr 0x80 in cycle 1 -> hold=5'b11111, no jump; in cycle 5 jump_en_o=1, jump_addr_o=0x80, flush=5'b01110, single pulse only.
REQ-042 int_req_i with vector 0x100 during ex_hold of 2 cycles -> WAIT for 2 cycles, then one cycle of jump_en_o=1, addr 0x100, int_ack_o=1.
REQ-043 id_hold and jump_req_i in the same cycle -> jump wins: hold_en_o=0, flush_en_o=5'b01110.
REQ-044 TIMEOUT=4 with bus_hold for 10 cycles -> hold_timeout_o pulses once, in cycle 4; it pulses again only after hold drops and re-accrues.
REQ-045 rst asserted during WAIT -> all outputs 0 immediately; no int_ack_o after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stage indices, reset level
// and interrupt FSM encodings.
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;

    typedef enum logic [1:0] {
        INT_IDLE  = 2'd0,
        INT_WAIT  = 2'd1,
        INT_ISSUE = 2'd2
    } int_state_e;

endpackage

// File: rtl/pipe_ctrl_hold_timer.sv
// Counts consecutive hold cycles and pulses once when the run reaches TIMEOUT.
module hold_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic timeout
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] SAT  = 8'(TIMEOUT);

    logic [7:0] cnt;

    // Parks one past LAST so the pulse cannot repeat until the hold run ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE)
            cnt <= '0;
        else if (!hold)
            cnt <= '0;
        else if (cnt != SAT)
            cnt <= cnt + 8'd1;
    end

    assign timeout = hold && (cnt == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/redirect controller with deferred jumps and a
// three-state interrupt issue FSM.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE   = 5,
    parameter int ID_STAGE = STG_ID,
    parameter int EX_STAGE = STG_EX,
    parameter int ADDR_W   = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_hold_req_i,
    input  logic              ex_hold_req_i,
    input  logic              id_hold_req_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic [NSTAGE-1:0] hold_en_o,
    output logic [NSTAGE-1:0] flush_en_o,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              int_ack_o,
    output logic              hold_timeout_o
);

    localparam logic [NSTAGE-1:0] ONE          = NSTAGE'(1);
    localparam logic [NSTAGE-1:0] EX_HOLD_M    = (ONE << (EX_STAGE + 1)) - ONE;
    localparam logic [NSTAGE-1:0] EX_FLUSH_M   = ONE << (EX_STAGE + 1);
    localparam logic [NSTAGE-1:0] ID_HOLD_M    = (ONE << (ID_STAGE + 1)) - ONE;
    localparam logic [NSTAGE-1:0] ID_FLUSH_M   = ONE << (ID_STAGE + 1);
    localparam logic [NSTAGE-1:0] REDIR_FLUSH  = EX_HOLD_M & ~ONE;

    int_state_e        state, state_nxt;
    logic              jump_pend;
    logic [ADDR_W-1:0] jump_addr_q;
    logic [ADDR_W-1:0] int_addr_q;
    logic              any_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE)
            state <= INT_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INT_IDLE:  if (int_req_i) state_nxt = INT_WAIT;
            INT_WAIT:  if (!bus_hold_req_i && !ex_hold_req_i && !jump_req_i && !jump_pend)
                           state_nxt = INT_ISSUE;
            INT_ISSUE: state_nxt = INT_IDLE;
            default:   state_nxt = INT_IDLE;
        endcase
    end

    // A jump that cannot issue now (bus stall or interrupt issue) is parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            jump_pend   <= 1'b0;
            jump_addr_q <= '0;
            int_addr_q  <= '0;
        end else begin
            if (state == INT_IDLE && int_req_i)
                int_addr_q <= int_addr_i;
            if (jump_req_i && (bus_hold_req_i || state == INT_ISSUE)) begin
                jump_pend   <= 1'b1;
                jump_addr_q <= jump_addr_i;
            end else if (!bus_hold_req_i && state != INT_ISSUE) begin
                jump_pend   <= 1'b0;
            end
        end
    end

    always_comb begin
        hold_en_o   = '0;
        flush_en_o  = '0;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        int_ack_o   = 1'b0;
        if (rst == RST_ENABLE) begin
            hold_en_o = '0;
        end else if (state == INT_ISSUE) begin
            jump_en_o   = 1'b1;
            jump_addr_o = int_addr_q;
            flush_en_o  = REDIR_FLUSH;
            int_ack_o   = 1'b1;
        end else if (bus_hold_req_i) begin
            hold_en_o = '1;
        end else if (jump_req_i || jump_pend) begin
            jump_en_o   = 1'b1;
            jump_addr_o = jump_req_i ? jump_addr_i : jump_addr_q;
            flush_en_o  = REDIR_FLUSH;
        end else if (ex_hold_req_i) begin
            hold_en_o  = EX_HOLD_M;
            flush_en_o = EX_FLUSH_M;
        end else if (id_hold_req_i) begin
            hold_en_o  = ID_HOLD_M;
            flush_en_o = ID_FLUSH_M;
        end
    end

    assign any_hold = |hold_en_o;

    hold_timer #(.TIMEOUT(TIMEOUT)) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .hold    (any_hold),
        .timeout (hold_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl (TIMEOUT=4 so the timeout path is short).
module tb_pipe_ctrl;

    typedef struct {
        logic        bus, ex, id, jreq;
        logic [31:0] jaddr;
        logic        ireq;
        logic [31:0] iaddr;
        logic [4:0]  hold, flush;
        logic        jen;
        logic [31:0] jout;
        logic        ack, to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_hold_req_i, ex_hold_req_i, id_hold_req_i, jump_req_i, int_req_i;
    logic [31:0] jump_addr_i, int_addr_i, jump_addr_o;
    logic [4:0]  hold_en_o, flush_en_o;
    logic        jump_en_o, int_ack_o, hold_timeout_o;

    int n_vec = 0;
    int n_bad = 0;

    pipe_ctrl #(.NSTAGE(5), .ID_STAGE(2), .EX_STAGE(3), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .bus_hold_req_i(bus_hold_req_i), .ex_hold_req_i(ex_hold_req_i),
        .id_hold_req_i(id_hold_req_i), .jump_req_i(jump_req_i),
        .jump_addr_i(jump_addr_i), .int_req_i(int_req_i), .int_addr_i(int_addr_i),
        .hold_en_o(hold_en_o), .flush_en_o(flush_en_o), .jump_en_o(jump_en_o),
        .jump_addr_o(jump_addr_o), .int_ack_o(int_ack_o), .hold_timeout_o(hold_timeout_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input bit bus, ex, id, jreq, input logic [31:0] ja,
                               input bit ireq, input logic [31:0] ia,
                               input logic [4:0] h, f, input bit jen, input logic [31:0] jo,
                               input bit ack, to);
        vec_t v;
        v.bus = bus; v.ex = ex; v.id = id; v.jreq = jreq; v.jaddr = ja;
        v.ireq = ireq; v.iaddr = ia; v.hold = h; v.flush = f;
        v.jen = jen; v.jout = jo; v.ack = ack; v.to = to;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus_hold_req_i = v.bus; ex_hold_req_i = v.ex; id_hold_req_i = v.id;
        jump_req_i = v.jreq; jump_addr_i = v.jaddr;
        int_req_i = v.ireq; int_addr_i = v.iaddr;
    endtask

    task automatic check(input vec_t v, input string nm);
        n_vec++;
        if (hold_en_o !== v.hold || flush_en_o !== v.flush || jump_en_o !== v.jen ||
            jump_addr_o !== v.jout || int_ack_o !== v.ack || hold_timeout_o !== v.to) begin
            n_bad++;
            $display("FAIL %s: got hold=%b flush=%b jen=%b jaddr=%h ack=%b to=%b, want hold=%b flush=%b jen=%b jaddr=%h ack=%b to=%b",
                     nm, hold_en_o, flush_en_o, jump_en_o, jump_addr_o, int_ack_o, hold_timeout_o,
                     v.hold, v.flush, v.jen, v.jout, v.ack, v.to);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        drive(v);
        @(negedge clk);
        check(v, nm);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t z;

    initial begin
        z = V(0,0,0,0,0, 0,0, 5'b00000,5'b00000,0,0,0,0);

        // Reset with every request active: outputs stay quiet.
        rst = 1'b1;
        drive(V(1,1,1,1,32'h55, 1,32'h66, 0,0,0,0,0,0));
        @(negedge clk);
        check(z, "reset_quiet");
        @(posedge clk);
        #1;
        rst = 1'b0;

        //        bus ex id jr jaddr   ir iaddr  hold      flush     jen jout    ack to
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,1,0,0,0,       0,0,    5'b01111,5'b10000,0,0,       0,0));
        tbl.push_back(V(0,1,0,0,0,       0,0,    5'b01111,5'b10000,0,0,       0,0));
        tbl.push_back(V(0,1,0,0,0,       0,0,    5'b01111,5'b10000,0,0,       0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,0,1,0,0,       0,0,    5'b00111,5'b01000,0,0,       0,0));
        tbl.push_back(V(0,0,1,1,32'h44,  0,0,    5'b00000,5'b01110,1,32'h44,  0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,0,0,1,32'h10,  0,0,    5'b00000,5'b01110,1,32'h10,  0,0));
        tbl.push_back(V(0,1,1,0,0,       0,0,    5'b01111,5'b10000,0,0,       0,0));
        tbl.push_back(V(1,1,0,0,0,       0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,1,32'h80,  0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,0,0,       0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,0,0,       0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,0,0,       0,0,    5'b11111,5'b00000,0,0,       0,1));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b01110,1,32'h80,  0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,1,32'h20,  0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(1,0,0,1,32'h24,  0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b01110,1,32'h24,  0,0));
        tbl.push_back(V(1,0,0,1,32'h30,  0,0,    5'b11111,5'b00000,0,0,       0,0));
        tbl.push_back(V(0,0,0,1,32'h28,  0,0,    5'b00000,5'b01110,1,32'h28,  0,0));
        tbl.push_back(V(0,0,0,0,0,       0,0,    5'b00000,5'b00000,0,0,       0,0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("table[%0d]", i));

        // Interrupt held off by a two-cycle EX stall, then issued once.
        apply(V(0,1,0,0,0, 1,32'h100, 5'b01111,5'b10000,0,0,0,0), "int_exhold_a");
        apply(V(0,1,0,0,0, 0,0,       5'b01111,5'b10000,0,0,0,0), "int_exhold_b");
        apply(z,                                                   "int_wait_c");
        apply(V(0,0,0,0,0, 0,0, 5'b00000,5'b01110,1,32'h100,1,0),  "int_issue");
        apply(z,                                                   "int_after");

        // Jump and bus stall arriving during ISSUE: issue goes ahead, jump follows.
        apply(V(0,0,0,0,0, 1,32'h200, 0,0,0,0,0,0),                "int2_req");
        apply(z,                                                   "int2_wait");
        apply(V(1,0,0,1,32'h300, 0,0, 5'b00000,5'b01110,1,32'h200,1,0), "int2_issue_jump");
        apply(V(0,0,0,0,0, 0,0, 5'b00000,5'b01110,1,32'h300,0,0),  "int2_deferred_jump");
        apply(z,                                                   "int2_after");

        // Ten-cycle bus stall: one timeout pulse in cycle 4, another after re-accrual.
        for (int c = 1; c <= 10; c++)
            apply(V(1,0,0,0,0, 0,0, 5'b11111,5'b00000,0,0,0,(c == 4)),
                  $sformatf("timeout_run1_c%0d", c));
        apply(z, "timeout_gap");
        for (int c = 1; c <= 4; c++)
            apply(V(1,0,0,0,0, 0,0, 5'b11111,5'b00000,0,0,0,(c == 4)),
                  $sformatf("timeout_run2_c%0d", c));
        apply(z, "timeout_end");

        // Reset while WAITing with a pending jump and a partial hold count.
        apply(V(1,0,0,1,32'h500, 1,32'h400, 5'b11111,5'b00000,0,0,0,0), "rstw_a");
        apply(V(1,0,0,0,0,       0,0,       5'b11111,5'b00000,0,0,0,0), "rstw_b");
        drive(V(1,0,0,1,32'h600, 1,32'h700, 0,0,0,0,0,0));
        #2;
        rst = 1'b1;
        #1;
        check(z, "rstw_async_zero");
        @(negedge clk);
        check(z, "rstw_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= 3; c++)
            apply(V(1,0,0,0,0, 0,0, 5'b11111,5'b00000,0,0,0,0), $sformatf("rstw_cnt_c%0d", c));
        for (int c = 1; c <= 3; c++)
            apply(z, $sformatf("rstw_no_ack_c%0d", c));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
